// File: rtl/piano_note_detect.sv
// piano_note_detect
//
// Tone receiver for the FPGA piano. Measures the half-period of the piano's
// square-wave FREQ output in CLK cycles. Each measurement is classified
// against the eight-note scale (C4..C5). A note is reported once MATCH_N
// consecutive measurements agree.
//
// Parameters:
//   CLK_DIV_SHIFT  nominal half-period table is right-shifted by this (0 = 100 MHz CLK)
//   TOL_SHIFT      per-note match tolerance is nominal >> TOL_SHIFT cycles
//   MATCH_N        consecutive identical classifications needed to lock (1..15)
//
// Ports:
//   CLK          in   system clock
//   RESET        in   synchronous, active-high reset
//   FREQ         in   asynchronous square-wave input
//   note         out  [7:0] one-hot locked note, bit 7 = C4 .. bit 0 = C5, 0 when none
//   valid        out  high while a note is locked
//   note_strobe  out  one-cycle pulse when valid rises
//   Led          out  [7:0] board LEDs
//
// Build option PIANO_DETECT_LED_EN:
//   defined   -> Led mirrors note
//   undefined -> Led shows the raw one-hot class of every measurement
//                (0 for no match), so jitter is visible during bring-up

module piano_note_detect #(
    parameter int CLK_DIV_SHIFT = 0,
    parameter int TOL_SHIFT     = 6,
    parameter int MATCH_N       = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FREQ,
    output logic [7:0] note,
    output logic       valid,
    output logic       note_strobe,
    output logic [7:0] Led
);

    localparam int               CNT_W     = 20;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [1:0]       IDLE      = 2'd0;
    localparam logic [1:0]       ACQ       = 2'd1;
    localparam logic [1:0]       LOCKED    = 2'd2;
    localparam logic [3:0]       MATCH_TGT = 4'(MATCH_N);

    // Nominal half-period of the note at one-hot bit idx, scaled to CLK.
    function automatic logic [CNT_W-1:0] nominal(input int idx);
        logic [CNT_W-1:0] base;
        case (idx)
            7:       base = 20'd191110;
            6:       base = 20'd170265;
            5:       base = 20'd151685;
            4:       base = 20'd143172;
            3:       base = 20'd127551;
            2:       base = 20'd113636;
            1:       base = 20'd101239;
            default: base = 20'd95557;
        endcase
        return base >> CLK_DIV_SHIFT;
    endfunction

    localparam logic [CNT_W-1:0] TIMEOUT = nominal(7) << 1;

    // One-hot class of a measurement; the lowest matching bit wins because
    // the scan runs from bit 7 down and later matches overwrite.
    function automatic logic [7:0] classify(input logic [CNT_W-1:0] meas);
        logic [7:0]              cls;
        logic [CNT_W-1:0]        nom;
        logic signed [CNT_W+1:0] diff;
        logic signed [CNT_W+1:0] tol;
        cls = 8'd0;
        if (meas != CNT_MAX) begin
            for (int i = 7; i >= 0; i--) begin
                nom  = nominal(i);
                tol  = $signed({2'b00, nom >> TOL_SHIFT});
                diff = $signed({2'b00, meas}) - $signed({2'b00, nom});
                if (diff[CNT_W+1]) begin
                    diff = -diff;
                end
                if (diff <= tol) begin
                    cls        = 8'd0;
                    cls[3'(i)] = 1'b1;
                end
            end
        end
        return cls;
    endfunction

    logic [1:0]       state;
    logic [7:0]       cand;
    logic [3:0]       count;

    // Stage p0: synchronise FREQ, register both-edge pulse, count cycles since last edge
    logic             freq_s1_p0;
    logic             freq_s2_p0;
    logic             freq_s3_p0;
    logic             edge_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             timeout_p0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            freq_s1_p0 <= 1'b0;
            freq_s2_p0 <= 1'b0;
            freq_s3_p0 <= 1'b0;
            edge_p0    <= 1'b0;
            cnt_p0     <= '0;
        end else begin
            freq_s1_p0 <= FREQ;
            freq_s2_p0 <= freq_s1_p0;
            freq_s3_p0 <= freq_s2_p0;
            edge_p0    <= freq_s2_p0 ^ freq_s3_p0;
            // Loading 1 counts the edge cycle itself, so the value seen on the
            // next edge cycle equals the edge spacing.
            if (edge_p0) begin
                cnt_p0 <= CNT_W'(1);
            end else if (cnt_p0 != CNT_MAX) begin
                cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

    // An edge on the timeout cycle takes priority.
    assign timeout_p0 = (cnt_p0 == TIMEOUT) && !edge_p0;

    // Stage p1: registered classification; the reference edge (state IDLE) carries no measurement
    logic [7:0] cls_p1;
    logic       vld_p1;

    always_ff @(posedge CLK) begin
        cls_p1 <= classify(cnt_p0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= edge_p0 && (state != IDLE);
        end
    end

    // Stage p2: acquisition / lock FSM driving note, valid and note_strobe
    logic [3:0] next_count;

    always_comb begin
        next_count = 4'd0;
        if ((cls_p1 != 8'd0) && (cls_p1 == cand)) begin
            next_count = count + 4'd1;
        end else if (cls_p1 != 8'd0) begin
            next_count = 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cand        <= 8'd0;
            count       <= 4'd0;
            note        <= 8'd0;
            valid       <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_p0) begin
                        state <= ACQ;
                        cand  <= 8'd0;
                        count <= 4'd0;
                    end
                end
                ACQ: begin
                    if (timeout_p0) begin
                        state <= IDLE;
                        cand  <= 8'd0;
                        count <= 4'd0;
                    end else if (vld_p1) begin
                        cand  <= cls_p1;
                        count <= next_count;
                        if ((cls_p1 != 8'd0) && (next_count >= MATCH_TGT)) begin
                            state       <= LOCKED;
                            note        <= cls_p1;
                            valid       <= 1'b1;
                            note_strobe <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (timeout_p0) begin
                        state <= IDLE;
                        cand  <= 8'd0;
                        count <= 4'd0;
                        note  <= 8'd0;
                        valid <= 1'b0;
                    end else if (vld_p1 && (cls_p1 != note)) begin
                        state <= ACQ;
                        cand  <= cls_p1;
                        count <= (cls_p1 != 8'd0) ? 4'd1 : 4'd0;
                        note  <= 8'd0;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PIANO_DETECT_LED_EN
    assign Led = note;
`else
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Led <= 8'd0;
        end else if (vld_p1) begin
            Led <= cls_p1;
        end
    end
`endif

endmodule

// File: tb/tb_piano_note_detect.sv
// Testbench for piano_note_detect with CLK_DIV_SHIFT = 10 (N = 186,166,148,139,
// 124,110,98,93; T = 372), MATCH_N = 4, TOL_SHIFT = 6.
// A FREQ toggle just after posedge k shows as an edge pulse in cycle k+3 and
// as note/valid/strobe changes in cycle k+5.

module tb_piano_note_detect;

    localparam logic [7:0] C4 = 8'b1000_0000;
    localparam logic [7:0] E4 = 8'b0010_0000;
    localparam logic [7:0] A4 = 8'b0000_0100;
    localparam logic [7:0] C5 = 8'b0000_0001;

`ifdef PIANO_DETECT_LED_EN
    localparam bit LED_IS_NOTE = 1'b1;
`else
    localparam bit LED_IS_NOTE = 1'b0;
`endif

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       FREQ  = 1'b0;
    logic [7:0] note;
    logic       valid;
    logic       note_strobe;
    logic [7:0] Led;

    piano_note_detect #(
        .CLK_DIV_SHIFT(10),
        .TOL_SHIFT    (6),
        .MATCH_N      (4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FREQ       (FREQ),
        .note       (note),
        .valid      (valid),
        .note_strobe(note_strobe),
        .Led        (Led)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int strobes = 0;
    always @(negedge CLK) if (note_strobe === 1'b1) strobes++;

    int checks   = 0;
    int failures = 0;

    // Per-edge stimulus and captured outputs
    int         hp [32];
    logic       v_pre [32];
    logic       v_post[32];
    logic       s_post[32];
    logic       s_next[32];
    logic [7:0] n_post[32];
    logic [7:0] l_post[32];
    int         last_tog;

    function automatic logic [7:0] exp_led(input logic [7:0] note_e, input logic [7:0] cls_e);
        return LED_IS_NOTE ? note_e : cls_e;
    endfunction

    task automatic fill_hp(input int h);
        for (int i = 0; i < 32; i++) hp[i] = h;
    endtask

    // Called just after a posedge. Toggle j happens at cycle k; outputs are
    // captured in cycles k+4 (before), k+5 (after) and k+6, then the task
    // waits until posedge k+hp[j].
    task automatic drive_edges(input int n);
        for (int j = 0; j < n; j++) begin
            FREQ     = ~FREQ;
            last_tog = cyc;
            repeat (4) @(posedge CLK);
            @(negedge CLK);
            v_pre[j] = valid;
            @(posedge CLK);
            @(negedge CLK);
            v_post[j] = valid;
            n_post[j] = note;
            s_post[j] = note_strobe;
            l_post[j] = Led;
            @(posedge CLK);
            @(negedge CLK);
            s_next[j] = note_strobe;
            repeat (hp[j] - 6) @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        FREQ  = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        FREQ  = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) begin
            FREQ = ~FREQ;
            @(negedge CLK);
            checks++;
            if ({note, valid, note_strobe, Led} !== 18'd0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: note=%b valid=%b strobe=%b Led=%b, required all 0",
                         i, note, valid, note_strobe, Led);
            end
            @(posedge CLK);
            #1;
        end
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({note, valid, note_strobe, Led} !== 18'd0) begin
            failures++;
            $display("FAIL reset_idle: note=%b valid=%b strobe=%b Led=%b, required all 0",
                     note, valid, note_strobe, Led);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_lock_a4;
        int s0;
        s0 = strobes;
        fill_hp(110);
        drive_edges(5);
        checks++; if (v_post[3] !== 1'b0) begin failures++; $display("FAIL a4_early_valid: got %b, required 0", v_post[3]); end
        checks++; if (v_pre[4] !== 1'b0) begin failures++; $display("FAIL a4_pre_valid: got %b, required 0", v_pre[4]); end
        checks++; if (v_post[4] !== 1'b1) begin failures++; $display("FAIL a4_valid: got %b, required 1", v_post[4]); end
        checks++; if (n_post[4] !== A4) begin failures++; $display("FAIL a4_note: got %b, required %b", n_post[4], A4); end
        checks++; if (s_post[4] !== 1'b1) begin failures++; $display("FAIL a4_strobe: got %b, required 1", s_post[4]); end
        checks++; if (s_next[4] !== 1'b0) begin failures++; $display("FAIL a4_strobe_end: got %b, required 0", s_next[4]); end
        checks++; if (strobes - s0 !== 1) begin failures++; $display("FAIL a4_strobe_count: got %0d, required 1", strobes - s0); end
        checks++; if (l_post[0] !== 8'd0) begin failures++; $display("FAIL a4_led_ref: got %b, required 0", l_post[0]); end
        checks++; if (l_post[1] !== exp_led(8'd0, A4)) begin failures++; $display("FAIL a4_led_meas: got %b, required %b", l_post[1], exp_led(8'd0, A4)); end
    endtask

    task automatic test_switch_c5;
        int s0;
        s0 = strobes;
        fill_hp(93);
        drive_edges(5);
        checks++; if (v_post[0] !== 1'b1 || n_post[0] !== A4) begin failures++; $display("FAIL sw_hold: valid=%b note=%b, required 1 %b", v_post[0], n_post[0], A4); end
        checks++; if (v_post[1] !== 1'b0 || n_post[1] !== 8'd0) begin failures++; $display("FAIL sw_drop: valid=%b note=%b, required 0 0", v_post[1], n_post[1]); end
        checks++; if (l_post[1] !== exp_led(8'd0, C5)) begin failures++; $display("FAIL sw_led: got %b, required %b", l_post[1], exp_led(8'd0, C5)); end
        checks++; if (v_post[3] !== 1'b0) begin failures++; $display("FAIL sw_acq_valid: got %b, required 0", v_post[3]); end
        checks++; if (v_post[4] !== 1'b1 || n_post[4] !== C5) begin failures++; $display("FAIL sw_lock: valid=%b note=%b, required 1 %b", v_post[4], n_post[4], C5); end
        checks++; if (strobes - s0 !== 1) begin failures++; $display("FAIL sw_strobe_count: got %0d, required 1", strobes - s0); end
    endtask

    task automatic test_no_match;
        int s0;
        do_reset(2);
        s0 = strobes;
        fill_hp(117);
        drive_edges(20);
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (v_post[j] !== 1'b0 || n_post[j] !== 8'd0 || l_post[j] !== 8'd0) begin
                failures++;
                $display("FAIL nomatch[%0d]: valid=%b note=%b Led=%b, required 0 0 0", j, v_post[j], n_post[j], l_post[j]);
            end
        end
        checks++; if (strobes - s0 !== 0) begin failures++; $display("FAIL nomatch_strobe_count: got %0d, required 0", strobes - s0); end
    endtask

    task automatic test_tolerance;
        do_reset(2);
        hp[0] = 111; hp[1] = 109; hp[2] = 111; hp[3] = 109; hp[4] = 112; hp[5] = 110;
        drive_edges(6);
        checks++; if (l_post[2] !== exp_led(8'd0, A4)) begin failures++; $display("FAIL tol_led_109: got %b, required %b", l_post[2], exp_led(8'd0, A4)); end
        checks++; if (v_post[3] !== 1'b0) begin failures++; $display("FAIL tol_early_valid: got %b, required 0", v_post[3]); end
        checks++; if (v_post[4] !== 1'b1 || n_post[4] !== A4) begin failures++; $display("FAIL tol_lock: valid=%b note=%b, required 1 %b", v_post[4], n_post[4], A4); end
        checks++; if (v_post[5] !== 1'b0 || n_post[5] !== 8'd0) begin failures++; $display("FAIL tol_112_drop: valid=%b note=%b, required 0 0", v_post[5], n_post[5]); end
        checks++; if (l_post[5] !== 8'd0) begin failures++; $display("FAIL tol_led_112: got %b, required 0", l_post[5]); end
    endtask

    task automatic test_timeout;
        int s0;
        int n;
        do_reset(2);
        fill_hp(186);
        drive_edges(5);
        checks++; if (v_post[4] !== 1'b1 || n_post[4] !== C4) begin failures++; $display("FAIL to_lock: valid=%b note=%b, required 1 %b", v_post[4], n_post[4], C4); end
        // Edge pulse at last_tog+3; valid must fall 373 cycles later.
        n = last_tog + 375 - cyc;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL to_hold: valid=%b, required 1", valid); end
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (valid !== 1'b0 || note !== 8'd0) begin failures++; $display("FAIL to_fall: valid=%b note=%b, required 0 0", valid, note); end
        @(posedge CLK);
        #1;
        s0 = strobes;
        fill_hp(186);
        hp[4] = 372;
        drive_edges(5);
        checks++; if (v_post[3] !== 1'b0) begin failures++; $display("FAIL to_reacq_early: got %b, required 0", v_post[3]); end
        checks++; if (v_post[4] !== 1'b1 || n_post[4] !== C4) begin failures++; $display("FAIL to_relock: valid=%b note=%b, required 1 %b", v_post[4], n_post[4], C4); end
        checks++; if (strobes - s0 !== 1) begin failures++; $display("FAIL to_strobe_count: got %0d, required 1", strobes - s0); end
    endtask

    // Follows test_timeout: the last gap was exactly T, so the edge and the
    // timeout coincide and the edge must win.
    task automatic test_timeout_edge_race;
        fill_hp(186);
        drive_edges(5);
        checks++; if (v_pre[0] !== 1'b1) begin failures++; $display("FAIL race_no_timeout: valid=%b, required 1", v_pre[0]); end
        checks++; if (v_post[0] !== 1'b0) begin failures++; $display("FAIL race_drop: valid=%b, required 0", v_post[0]); end
        checks++; if (v_post[3] !== 1'b0) begin failures++; $display("FAIL race_early: valid=%b, required 0", v_post[3]); end
        checks++; if (v_post[4] !== 1'b1 || n_post[4] !== C4) begin failures++; $display("FAIL race_lock: valid=%b note=%b, required 1 %b", v_post[4], n_post[4], C4); end
    endtask

    task automatic test_reset_mid_lock;
        int s0;
        do_reset(2);
        fill_hp(148);
        drive_edges(6);
        checks++; if (v_post[5] !== 1'b1 || n_post[5] !== E4) begin failures++; $display("FAIL mid_lock: valid=%b note=%b, required 1 %b", v_post[5], n_post[5], E4); end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if ({note, valid, note_strobe, Led} !== 18'd0) begin
            failures++;
            $display("FAIL mid_reset_clear: note=%b valid=%b strobe=%b Led=%b, required all 0", note, valid, note_strobe, Led);
        end
        @(posedge CLK);
        #1;
        s0 = strobes;
        fill_hp(148);
        drive_edges(5);
        checks++; if (l_post[0] !== 8'd0) begin failures++; $display("FAIL mid_led_ref: got %b, required 0", l_post[0]); end
        checks++; if (l_post[1] !== exp_led(8'd0, E4)) begin failures++; $display("FAIL mid_led_meas: got %b, required %b", l_post[1], exp_led(8'd0, E4)); end
        checks++; if (v_post[3] !== 1'b0) begin failures++; $display("FAIL mid_early: valid=%b, required 0", v_post[3]); end
        checks++; if (v_post[4] !== 1'b1 || n_post[4] !== E4) begin failures++; $display("FAIL mid_relock: valid=%b note=%b, required 1 %b", v_post[4], n_post[4], E4); end
        checks++; if (strobes - s0 !== 1) begin failures++; $display("FAIL mid_strobe_count: got %0d, required 1", strobes - s0); end
    endtask

    initial begin
        test_reset;
        test_lock_a4;
        test_switch_c5;
        test_no_match;
        test_tolerance;
        test_timeout;
        test_timeout_edge_race;
        test_reset_mid_lock;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit exceeded");
    end

endmodule
